// File: rtl/ultra_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger:
// FSM state encoding and microsecond-to-cycle conversion helpers.
package ultra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

  localparam longint unsigned US_PER_S = 64'd1_000_000;

  // Cycles of clk_hz that fit in 'us' microseconds (64-bit product avoids overflow)
  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_hz);
    longint unsigned prod;
    prod = 64'(us) * 64'(clk_hz);
    return 32'(prod / US_PER_S);
  endfunction

  // Bits needed to hold the value n (at least 1)
  function automatic int unsigned bits_for(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ultra_sync.sv
// Single-bit 2-flop synchroniser with rise/fall pulses derived from the
// synchronised level (one extra flop holds the previous synchronised value).
module ultra_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Synchroniser chain plus previous-value flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Edge pulses on the synchronised level
  always_comb begin
    rise = s2 & ~s3;
    fall = ~s2 & s3;
  end

endmodule

// File: rtl/ultra_ranger_mc.sv
// Round-robin multi-channel ultrasonic ranger: triggers one sensor at a time,
// measures its synchronised echo width in clk cycles, reports per-channel
// width/near/timeout. Define ULTRA_AVG_EN to report the mean of the last four
// successful samples per channel instead of the raw latest sample.
module ultra_ranger_mc #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int N_CH       = 2,
  parameter int CNT_W      = 20,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int HOLDOFF_US = 60000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_CH-1:0]                    echo,
  output logic [N_CH-1:0]                    trig,
  input  logic [CNT_W-1:0]                   thresh,
  output logic [N_CH*CNT_W-1:0]              width,
  output logic [N_CH-1:0]                    near,
  output logic [N_CH-1:0]                    tmo,
  output logic                               valid,
  output logic [((N_CH>1)?$clog2(N_CH):1)-1:0] valid_ch
);
  import ultra_pkg::*;

  localparam int unsigned TRIG_CYC = us_to_cyc(TRIG_US, CLK_HZ);
  localparam int unsigned TMO_CYC  = us_to_cyc(TIMEOUT_US, CLK_HZ);
  localparam int unsigned HOLD_CYC = us_to_cyc(HOLDOFF_US, CLK_HZ);
  localparam int unsigned PH_W     = bits_for((TRIG_CYC > HOLD_CYC) ? TRIG_CYC : HOLD_CYC);
  localparam int unsigned TM_W     = bits_for(TMO_CYC);
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t           state, state_nx;
  logic [CH_W-1:0]  ch;
  logic [PH_W-1:0]  ph_cnt;
  logic [TM_W-1:0]  tm_cnt;
  logic [CNT_W-1:0] wcnt;
  logic [N_CH-1:0]  rise_p, fall_p;
  logic             rise_ch, fall_ch, trig_done, hold_done, tmo_hit, done_ok;
  logic [CNT_W-1:0] width_r [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    ultra_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (echo[i]),
      .rise (rise_p[i]),
      .fall (fall_p[i])
    );
  end

  // Per-cycle event decode for the channel currently being served
  always_comb begin
    rise_ch   = rise_p[ch];
    fall_ch   = fall_p[ch];
    trig_done = (ph_cnt == PH_W'(TRIG_CYC - 1));
    hold_done = (ph_cnt == PH_W'(HOLD_CYC - 1));
    tmo_hit   = ((state == ST_WAIT_ECHO) || (state == ST_MEASURE)) &&
                (tm_cnt == TM_W'(TMO_CYC - 1));
    // timeout wins over a coincident falling edge
    done_ok   = (state == ST_MEASURE) && fall_ch && !tmo_hit;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      state_nx = ST_TRIG;
      ST_TRIG:      if (trig_done) state_nx = ST_WAIT_ECHO;
      ST_WAIT_ECHO: if (tmo_hit) state_nx = ST_HOLDOFF;
                    else if (rise_ch) state_nx = ST_MEASURE;
      ST_MEASURE:   if (tmo_hit || fall_ch) state_nx = ST_HOLDOFF;
      ST_HOLDOFF:   if (hold_done) state_nx = ST_TRIG;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // Trigger output: only the served channel, only in TRIG
  always_comb begin
    trig = '0;
    if (state == ST_TRIG) trig[ch] = 1'b1;
  end

  // Counters, channel pointer and completion reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      ch       <= '0;
      ph_cnt   <= '0;
      tm_cnt   <= '0;
      wcnt     <= '0;
      tmo      <= '0;
      valid    <= 1'b0;
      valid_ch <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_TRIG: begin
          tm_cnt <= '0;
          ph_cnt <= trig_done ? '0 : ph_cnt + 1'b1;
        end
        ST_WAIT_ECHO, ST_MEASURE: begin
          tm_cnt <= tm_cnt + 1'b1;
          if (state == ST_WAIT_ECHO) begin
            if (rise_ch) wcnt <= CNT_W'(1);
          end else if (!fall_ch && (wcnt != '1)) begin
            wcnt <= wcnt + 1'b1;
          end
          if (done_ok || tmo_hit) begin
            valid    <= 1'b1;
            valid_ch <= ch;
            tmo[ch]  <= tmo_hit;
          end
        end
        ST_HOLDOFF: begin
          ph_cnt <= hold_done ? '0 : ph_cnt + 1'b1;
          if (hold_done) ch <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ULTRA_AVG_EN
  // Three previous samples per channel; with the new sample they form the 4-deep window
  logic [CNT_W-1:0] hist [N_CH][3];
  logic [N_CH-1:0]  primed;
  logic [CNT_W+1:0] avg_sum;

  // Window sum including the sample being latched
  always_comb begin
    avg_sum = {2'b00, wcnt} + {2'b00, hist[ch][0]} + {2'b00, hist[ch][1]} + {2'b00, hist[ch][2]};
  end

  // Averaged width; first sample after reset fills the whole window
  always_ff @(posedge clk) begin
    if (rst) begin
      primed <= '0;
      for (int unsigned k = 0; k < N_CH; k++) width_r[k] <= '0;
    end else if (done_ok) begin
      if (!primed[ch]) begin
        primed[ch]  <= 1'b1;
        hist[ch][0] <= wcnt;
        hist[ch][1] <= wcnt;
        hist[ch][2] <= wcnt;
        width_r[ch] <= wcnt;
      end else begin
        hist[ch][2] <= hist[ch][1];
        hist[ch][1] <= hist[ch][0];
        hist[ch][0] <= wcnt;
        width_r[ch] <= avg_sum[CNT_W+1:2];
      end
    end
  end
`else
  // Raw width: latest successful sample per channel
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_CH; k++) width_r[k] <= '0;
    end else if (done_ok) begin
      width_r[ch] <= wcnt;
    end
  end
`endif

  // Flattened width bus and near flags
  always_comb begin
    width = '0;
    near  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      width[k*CNT_W +: CNT_W] = width_r[k];
      near[k] = (width_r[k] < thresh) && !tmo[k];
    end
  end

endmodule

// File: tb/tb_ultra_ranger_mc.sv
// Randomized scoreboard bench for ultra_ranger_mc, using a 1 MHz parameter set
// so one microsecond equals one clk cycle and runs stay short.
module tb_ultra_ranger_mc;

  localparam int CLK_HZ     = 1_000_000;
  localparam int N_CH       = 2;
  localparam int CNT_W      = 9;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 600;
  localparam int HOLDOFF_US = 40;
  localparam int TRIG_CYC   = TRIG_US * (CLK_HZ / 1_000_000);
  localparam int TMO_CYC    = TIMEOUT_US * (CLK_HZ / 1_000_000);
  localparam int HOLD_CYC   = HOLDOFF_US * (CLK_HZ / 1_000_000);
  localparam int WMAX       = (1 << CNT_W) - 1;
  localparam int N_IT       = 40;

  logic                   clk, rst;
  logic [N_CH-1:0]        echo, trig, near, tmo;
  logic [CNT_W-1:0]       thresh;
  logic [N_CH*CNT_W-1:0]  width;
  logic                   valid;
  logic [0:0]             valid_ch;

  ultra_ranger_mc #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .CNT_W(CNT_W),
    .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US)
  ) dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .thresh(thresh),
    .width(width), .near(near), .tmo(tmo), .valid(valid), .valid_ch(valid_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   ch;
    int                   t;
    logic [N_CH*CNT_W-1:0] wv;
    logic [N_CH-1:0]      tv;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   last_valid = 0;

  // reference model state
  int   m_width [N_CH];
  bit   m_tmo   [N_CH];
  int   m_hist  [N_CH][$];
  int   next_ch;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N_CH*CNT_W-1:0] pack_w();
    logic [N_CH*CNT_W-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_width[k]);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] pack_t();
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = m_tmo[k];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] near_of(input logic [N_CH*CNT_W-1:0] wv,
                                              input logic [N_CH-1:0] tv);
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = (wv[k*CNT_W +: CNT_W] < thresh) && !tv[k];
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_width[k] = 0;
      m_tmo[k]   = 1'b0;
      m_hist[k].delete();
    end
    next_ch = 0;
  endfunction

  // One measurement outcome: a timeout leaves the width alone, a success stores
  // the (saturated) pulse length, optionally averaged over the last four.
  function automatic void model_result(input int c, input bit timed_out, input int h, input int t);
    exp_t e;
    int   s;
    if (timed_out) begin
      m_tmo[c] = 1'b1;
    end else begin
      s = (h > WMAX) ? WMAX : h;
      m_tmo[c] = 1'b0;
`ifdef ULTRA_AVG_EN
      if (m_hist[c].size() == 0) repeat (4) m_hist[c].push_back(s);
      else begin
        m_hist[c].push_back(s);
        void'(m_hist[c].pop_front());
      end
      m_width[c] = (m_hist[c][0] + m_hist[c][1] + m_hist[c][2] + m_hist[c][3]) / 4;
`else
      m_width[c] = s;
`endif
    end
    e.ch = c;
    e.t  = t;
    e.wv = pack_w();
    e.tv = pack_t();
    sb.push_back(e);
  endfunction

  task automatic wait_trig(output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 3 * TMO_CYC; i++) begin
      if (trig != '0) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Monitor: every valid pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid_ch=%0d at cycle %0d, expected no valid", valid_ch, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_time", cyc, e.t);
        check("valid_ch", valid_ch, e.ch);
        check("tmo_vec", tmo, e.tv);
        check("width_vec", width, e.wv);
        check("near_vec", near, near_of(e.wv, e.tv));
        last_valid = cyc;
      end
    end
  end

  // Stimulus: one randomized scenario per measurement slot
  initial begin
    int  c, sc, d, h, g, d1, tr, tf, len, rst_cyc;
    bit  ok, after_rst;
    logic [N_CH-1:0] nz;

    rst    = 1'b1;
    echo   = '0;
    thresh = CNT_W'(100);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_valid", valid, 0);
    check("rst_valid_ch", valid_ch, 0);
    check("rst_width", width, pack_w());
    check("rst_tmo", tmo, pack_t());
    check("rst_near", near, near_of(pack_w(), pack_t()));
    rst       = 1'b0;
    rst_cyc   = cyc;
    after_rst = 1'b1;

    for (int it = 0; it < N_IT; it++) begin
      c      = next_ch;
      thresh = CNT_W'($urandom_range(1, WMAX));
      wait_trig(ok, tr);
      if (!ok) begin
        n_chk++;
        n_fail++;
        $display("FAIL trig_start: got no trigger within %0d cycles, expected trig[%0d]", 3 * TMO_CYC, c);
        break;
      end
      check("trig_onehot", trig, 1 << c);
      if (after_rst) check("rst_to_trig", tr - rst_cyc, 1);
      else           check("holdoff_gap", tr - last_valid, HOLD_CYC);
      after_rst = 1'b0;

      sc = (it == 13 || it == 27) ? 6 : int'($urandom_range(0, 5));
      if (sc == 4) echo[c] = 1'b1;           // stale high already present during TRIG
      len = 0;
      while (trig[c] === 1'b1 && len < 4 * TRIG_CYC) begin
        len++;
        @(negedge clk);
      end
      check("trig_len", len, TRIG_CYC);
      tf = cyc;

      if (sc == 6) begin
        repeat (5) @(negedge clk);
        echo[c] = 1'b1;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        echo    = '0;
        rst_cyc = cyc;
        model_reset();
        after_rst = 1'b1;
        check("abort_trig", trig, 0);
        check("abort_valid", valid, 0);
        check("abort_valid_ch", valid_ch, 0);
        check("abort_width", width, pack_w());
        check("abort_tmo", tmo, pack_t());
        check("abort_near", near, near_of(pack_w(), pack_t()));
        continue;
      end

      d = 0; h = 0; d1 = 0; g = 0;
      case (sc)
        0: begin d = $urandom_range(0, 100); h = $urandom_range(1, 300); end
        1: begin d = $urandom_range(0, 5);   h = $urandom_range(520, TMO_CYC - 4 - d); end
        2: begin d = 0; h = 0; end
        3: begin d = $urandom_range(0, 50);  h = TMO_CYC - d + 10; end
        4: begin
          d1 = $urandom_range(1, 30);
          g  = $urandom_range(2, 20);
          d  = d1 + g;
          h  = $urandom_range(1, 200);
        end
        default: begin d = $urandom_range(0, 50); h = TMO_CYC - 4 - d + int'($urandom_range(0, 1)); end
      endcase

      // pulse sampled high for h edges is reported h cycles wide, 3 cycles after it ends
      ok = (h > 0) && (d + h + 3 <= TMO_CYC - 1);
      model_result(c, !ok, h, ok ? tf + d + h + 3 : tf + TMO_CYC);

      if (sc == 4) begin
        repeat (d1) @(negedge clk);
        echo[c] = 1'b0;
        repeat (g) @(negedge clk);
        echo[c] = 1'b1;
        repeat (h) @(negedge clk);
        echo[c] = 1'b0;
      end else if (h > 0) begin
        nz = (sc == 0) ? N_CH'($urandom) : '0;
        repeat (d) @(negedge clk);
        echo = nz | (N_CH'(1) << c);
        repeat (h) @(negedge clk);
        echo = '0;
      end
      next_ch = (c + 1) % N_CH;
    end

    for (int i = 0; i < 2 * TMO_CYC && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
